vga_dither_out: RTL and testbench

Downstream output stage between the pattern generator and the TinyVGA PMOD pins. Takes RGB444 colour computed per pixel, plus raw sync and display_on from the sync generator. Reduces colour to RGB222 with 4x4 ordered (Bayer) dithering, with optional per-frame temporal rotation. Delays sync and blanking to match the colour path and drives a registered PMOD byte.

---
 rtl/vga_dither_out.sv | 132 +++++++++++++
 tb/tb_vga_dither_out.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_dither_out.sv
// vga_dither_out: RGB444 -> RGB222 ordered-dither output stage for the TinyVGA PMOD.
// Two-stage pipeline. Stage 1 captures the Bayer threshold, the colours and the
// delayed sync/blank. Stage 2 quantizes, blanks and registers the PMOD byte.
// A per-frame counter can rotate the Bayer column so the pattern shifts every frame.

// Per-channel quantizer: 4-bit colour to 2-bit colour, with optional threshold bump.
module vga_dither_quant (
  input  logic [3:0] c_i,
  input  logic [1:0] t2_i,
  input  logic       dith_i,
  output logic [1:0] q_o
);
  // Round the top two bits up when the dropped fraction beats the threshold; saturate at 3.
  always_comb begin
    q_o = c_i[3:2];
    if (dith_i && (c_i[1:0] > t2_i) && (c_i[3:2] != 2'd3))
      q_o = c_i[3:2] + 2'd1;
  end
endmodule

module vga_dither_out #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  input  logic [1:0] pix_x_lo,
  input  logic [1:0] pix_y_lo,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       dither_en,
  input  logic       temporal_en,
  output logic [7:0] uo_out,
  output logic [1:0] frame_cnt
);
  localparam int  NUM_CH    = 3;
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic SYNC_ACT  = ~SYNC_ACTIVE_LOW;

  // 4x4 Bayer matrix, indexed {row, column}.
  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    case ({y, x})
      4'h0: bayer = 4'd0;   4'h1: bayer = 4'd8;   4'h2: bayer = 4'd2;   4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;  4'h5: bayer = 4'd4;   4'h6: bayer = 4'd14;  4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;   4'h9: bayer = 4'd11;  4'hA: bayer = 4'd1;   4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;  4'hD: bayer = 4'd7;   4'hE: bayer = 4'd13;  default: bayer = 4'd5;
    endcase
  endfunction

  logic [NUM_CH-1:0][3:0] col_d, col_q;
  logic [NUM_CH-1:0][1:0] q;
  logic [3:0]             t_d, t_q;
  logic [1:0]             xi;
  logic                   de_q, hs_q, vs_q, dith_q;
  logic [7:0]             uo_d, uo_q;
  logic                   vs_prev_q;
  logic [1:0]             fc_d, fc_q;

  // Channel 0 is red, 1 green, 2 blue.
  assign col_d = {b_in, g_in, r_in};
  // Temporal mode slides the column index by the frame count so the pattern walks.
  assign xi    = temporal_en ? (pix_x_lo + fc_q) : pix_x_lo;
  assign t_d   = bayer(pix_y_lo, xi);

  // Stage 1: threshold, raw colour, and sync/blank delayed to stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q    <= '0;
      col_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= SYNC_IDLE;
      vs_q   <= SYNC_IDLE;
      dith_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      col_q  <= col_d;
      de_q   <= display_on;
      hs_q   <= hsync_in;
      vs_q   <= vsync_in;
      dith_q <= dither_en;
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      vga_dither_quant u_quant (
        .c_i    (col_q[ch]),
        .t2_i   (t_q[3:2]),
        .dith_i (dith_q),
        .q_o    (q[ch])
      );
    end
  endgenerate

  // Assemble the PMOD byte; colour is forced dark outside active video.
  always_comb begin
    uo_d = {hs_q, 3'b000, vs_q, 3'b000};
    if (de_q)
      uo_d = {hs_q, q[2][0], q[1][0], q[0][0], vs_q, q[2][1], q[1][1], q[0][1]};
  end

  // Stage 2: registered output byte.
  always_ff @(posedge clk) begin
    if (reset) uo_q <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
    else       uo_q <= uo_d;
  end

  // Count once per vsync pulse, on its idle-to-asserted transition.
  always_comb begin
    fc_d = fc_q;
    if ((vs_prev_q != SYNC_ACT) && (vsync_in == SYNC_ACT))
      fc_d = fc_q + 2'd1;
  end

  // Frame counter and vsync history; reset parks history at idle so release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_q <= SYNC_IDLE;
      fc_q      <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      fc_q      <= fc_d;
    end
  end

  assign uo_out    = uo_q;
  assign frame_cnt = fc_q;
endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: table of single-pixel vectors plus latency, blanking,
// frame-counter, temporal and reset sequences.
module tb_vga_dither_out;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] r_in, g_in, b_in;
  logic [1:0] pix_x_lo, pix_y_lo;
  logic       display_on, hsync_in, vsync_in, dither_en, temporal_en;
  logic [7:0] uo_out;
  logic [1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  vga_dither_out dut (
    .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_x_lo(pix_x_lo), .pix_y_lo(pix_y_lo), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dither_en(dither_en),
    .temporal_en(temporal_en), .uo_out(uo_out), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r, g, b;
    logic [1:0] x, y;
    logic       de, hs, dith, temp;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [11];

  // PMOD byte from sync levels and hand-computed 2-bit colours.
  function automatic logic [7:0] pk(input logic hs, input logic vs,
                                    input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
    return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic [1:0] x, input logic [1:0] y, input logic de,
                       input logic hs, input logic dith, input logic temp);
    r_in = r; g_in = g; b_in = b; pix_x_lo = x; pix_y_lo = y;
    display_on = de; hsync_in = hs; dither_en = dith; temporal_en = temp;
  endtask

  initial begin
    reset = 1'b1; vsync_in = 1'b1;
    drive(4'h3, 4'hA, 4'h5, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);

    //              r     g     b     x     y     de hs dith temp  expected
    tbl[0]  = '{4'hF, 4'h6, 4'h9, 2'd0, 2'd0, 1, 1, 0, 0, pk(1, 1, 3, 1, 2)};
    tbl[1]  = '{4'h6, 4'h0, 4'h0, 2'd0, 2'd0, 1, 1, 1, 0, pk(1, 1, 2, 0, 0)};
    tbl[2]  = '{4'hF, 4'hF, 4'hF, 2'd0, 2'd0, 1, 1, 1, 0, pk(1, 1, 3, 3, 3)};
    tbl[3]  = '{4'hF, 4'hF, 4'hF, 2'd3, 2'd3, 1, 1, 1, 1, pk(1, 1, 3, 3, 3)};
    tbl[4]  = '{4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 0, 0, 1, 0, pk(0, 1, 0, 0, 0)};
    tbl[5]  = '{4'h5, 4'h6, 4'h7, 2'd1, 2'd1, 1, 1, 1, 0, pk(1, 1, 1, 2, 2)};
    tbl[6]  = '{4'hB, 4'hE, 4'h2, 2'd0, 2'd3, 1, 1, 1, 0, pk(1, 1, 2, 3, 0)};
    tbl[7]  = '{4'h1, 4'h4, 4'hD, 2'd2, 2'd2, 1, 1, 1, 0, pk(1, 1, 1, 1, 3)};
    tbl[8]  = '{4'h1, 4'h4, 4'hD, 2'd2, 2'd2, 1, 1, 0, 0, pk(1, 1, 0, 1, 3)};
    tbl[9]  = '{4'h8, 4'h4, 4'hC, 2'd0, 2'd0, 1, 0, 0, 0, pk(0, 1, 2, 1, 3)};
    tbl[10] = '{4'h3, 4'h2, 4'h3, 2'd1, 2'd0, 1, 1, 1, 0, pk(1, 1, 1, 0, 1)};

    // Reset with arbitrary inputs, then release with vsync held high.
    for (int i = 0; i < 3; i++) begin
      vsync_in = 1'(i & 1);
      tick();
    end
    chk("reset_uo", uo_out, 8'h88);
    chk("reset_fc", {6'd0, frame_cnt}, 8'h00);
    vsync_in = 1'b1;
    reset = 1'b0;
    tick();
    chk("post_reset_uo", uo_out, 8'h88);
    for (int i = 0; i < 3; i++) tick();
    chk("post_reset_fc", {6'd0, frame_cnt}, 8'h00);

    // Single-pixel vectors, each held long enough to traverse the pipeline.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].x, tbl[i].y,
            tbl[i].de, tbl[i].hs, tbl[i].dith, tbl[i].temp);
      tick(); tick();
      chk($sformatf("vec%0d", i), uo_out, tbl[i].exp);
    end
    chk("fc_still0", {6'd0, frame_cnt}, 8'h00);

    // Back-to-back dithered pixels across one Bayer row: R = 2,1,2,1.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(4'h6, 4'h0, 4'h0, 2'(i), 2'd0, 1, 1, 1, 0);
      tick();
      if (i == 0) chk("stream_lat1", uo_out, tbl[10].exp);
      if (i >= 1 && i <= 4)
        chk($sformatf("stream_x%0d", i - 1), uo_out,
            pk(1, 1, ((i - 1) % 2 == 0) ? 2'd2 : 2'd1, 0, 0));
    end

    // One-cycle blank plus hsync pulse lands exactly two cycles later.
    drive(4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1, 1, 0, 0);
    tick(); tick();
    chk("blank_pre", uo_out, pk(1, 1, 3, 0, 0));
    drive(4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 0, 0, 0, 0);
    tick();
    chk("blank_n1", uo_out, pk(1, 1, 3, 0, 0));
    drive(4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1, 1, 0, 0);
    tick();
    chk("blank_n2", uo_out, pk(0, 1, 0, 0, 0));
    tick();
    chk("blank_n3", uo_out, pk(1, 1, 3, 0, 0));

    // Four vsync pulses: counter steps 1,2,3,0, once per pulse.
    for (int k = 1; k <= 4; k++) begin
      vsync_in = 1'b0;
      tick();
      chk($sformatf("fc_edge%0d", k), {6'd0, frame_cnt}, 8'(k % 4));
      tick(); tick();
      chk($sformatf("fc_hold%0d", k), {6'd0, frame_cnt}, 8'(k % 4));
      chk($sformatf("vs_bit%0d", k), uo_out, pk(1, 0, 3, 0, 0));
      vsync_in = 1'b1;
      tick(); tick();
    end

    // Advance to frame 1, then temporal rotation shifts column 0 to 1.
    vsync_in = 1'b0; tick(); vsync_in = 1'b1; tick();
    chk("fc_one", {6'd0, frame_cnt}, 8'h01);
    drive(4'h6, 4'h0, 4'h0, 2'd0, 2'd0, 1, 1, 1, 1);
    tick();
    drive(4'h6, 4'h0, 4'h0, 2'd0, 2'd0, 1, 1, 1, 0);
    tick();
    chk("temporal_on", uo_out, pk(1, 1, 1, 0, 0));
    tick();
    chk("temporal_off", uo_out, pk(1, 1, 2, 0, 0));

    // Mid-frame reset discards the in-flight pixel and clears the frame count.
    drive(4'hF, 4'hF, 4'hF, 2'd0, 2'd0, 1, 1, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_uo", uo_out, 8'h88);
    chk("midrst_fc", {6'd0, frame_cnt}, 8'h00);
    reset = 1'b0;
    tick();
    chk("midrst_n1", uo_out, 8'h88);
    tick();
    chk("midrst_n2", uo_out, pk(1, 1, 3, 3, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
